// File: rtl/crossover_pkg.sv
// Shared definitions for the GA crossover engine: mode encodings, LFSR taps and
// the compile-time width checks.
package crossover_pkg;

    typedef enum logic [1:0] {
        XO_PASS    = 2'b00,
        XO_UNIFORM = 2'b01,
        XO_ONEPT   = 2'b10,
        XO_TWOPT   = 2'b11
    } xo_mode_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Legal when segments tile the gene, the segment count is a power of two in
    // 2..16 and every segment gets its own PROB_W-bit slice of the 32-bit LFSR.
    function automatic bit xo_cfg_legal(input int gene_w, input int seg_w, input int prob_w);
        int nseg;
        if (seg_w <= 0 || prob_w <= 0 || (gene_w % seg_w) != 0) return 1'b0;
        nseg = gene_w / seg_w;
        if (nseg < 2 || nseg > 16 || (nseg & (nseg - 1)) != 0) return 1'b0;
        return (nseg * prob_w) <= 32;
    endfunction

endpackage

// File: rtl/crossover_lfsr.sv
// 32-bit Galois LFSR with seed load (priority) and per-transaction advance.
module crossover_lfsr
    import crossover_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] lfsr
);

    logic [31:0] lfsr_q;

    // A zero seed would lock the register up, so it is replaced by 1.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr_q <= LFSR_SEED;
        else if (seed_load)
            lfsr_q <= (seed == 32'h0) ? 32'h0000_0001 : seed;
        else if (adv)
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/crossover_engine.sv
// Two-stage segment crossover: S1 registers parents plus the LFSR-derived select
// mask, S2 registers the muxed child. Both stages stall together on backpressure.
module crossover_engine
    import crossover_pkg::*;
#(
    parameter int          GENE_W    = 32,
    parameter int          SEG_W     = 8,
    parameter int          PROB_W    = 4,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [GENE_W-1:0]        parent_gene0,
    input  logic [GENE_W-1:0]        parent_gene1,
    input  logic [1:0]               mode,
    input  logic [PROB_W-1:0]        prob,
    input  logic                     bias,
    input  logic                     seed_load,
    input  logic [31:0]              seed,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [GENE_W-1:0]        child_gene,
    output logic [GENE_W/SEG_W-1:0]  sel_mask
);

    localparam int NSEG = GENE_W / SEG_W;
    localparam int L    = $clog2(NSEG);

    generate
        if (!xo_cfg_legal(GENE_W, SEG_W, PROB_W) || LFSR_SEED == 32'h0) begin : g_cfg_bad
            $error("crossover_engine: illegal GENE_W/SEG_W/PROB_W/LFSR_SEED combination");
        end
    endgenerate

    function automatic logic [NSEG-1:0] build_mask(input logic [31:0] r, input xo_mode_e m,
                                                   input logic [PROB_W-1:0] p, input logic b);
        logic [L-1:0]    c0, c1, lo, hi;
        logic [NSEG-1:0] mk;
        c0 = r[L-1:0];
        c1 = r[2*L-1:L];
        lo = (c0 < c1) ? c0 : c1;
        hi = (c0 < c1) ? c1 : c0;
        mk = '0;
        for (int i = 0; i < NSEG; i++) begin
            case (m)
                XO_UNIFORM: mk[i] = (r[i*PROB_W +: PROB_W] < p) ^ b;
                XO_ONEPT:   mk[i] = (i >= int'(c0));
                XO_TWOPT:   mk[i] = (i >= int'(lo)) && (i < int'(hi));
                default:    mk[i] = 1'b0;
            endcase
        end
        return mk;
    endfunction

    logic              en, acc;
    logic [31:0]       lfsr;
    logic              vld_p1, vld_p2;
    logic [GENE_W-1:0] gene0_p1, gene1_p1, child_mux, child_p2;
    logic [NSEG-1:0]   mask_p1, mask_p2;

    assign en       = !vld_p2 || out_ready;
    assign in_ready = en && !rst;
    assign acc      = in_valid && in_ready;

    crossover_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .adv       (acc),
        .lfsr      (lfsr)
    );

    // ---- S1: parents and mask from the LFSR value current at acceptance ----
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (en)
            vld_p1 <= acc;
        if (en && acc) begin
            gene0_p1 <= parent_gene0;
            gene1_p1 <= parent_gene1;
            mask_p1  <= build_mask(lfsr, xo_mode_e'(mode), prob, bias);
        end
    end

    always_comb begin
        child_mux = '0;
        for (int i = 0; i < NSEG; i++)
            child_mux[i*SEG_W +: SEG_W] = mask_p1[i] ? gene1_p1[i*SEG_W +: SEG_W]
                                                     : gene0_p1[i*SEG_W +: SEG_W];
    end

    // ---- S2: registered child, mask and valid ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            child_p2 <= '0;
            mask_p2  <= '0;
        end else if (en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                child_p2 <= child_mux;
                mask_p2  <= mask_p1;
            end
        end
    end

    assign out_valid  = vld_p2;
    assign child_gene = child_p2;
    assign sel_mask   = mask_p2;

endmodule

// File: tb/tb_crossover_engine.sv
// Directed and randomized bench for crossover_engine against a queue-based
// reference model of the crossover rules.
module tb_crossover_engine;

    localparam int          GENE_W = 32;
    localparam int          SEG_W  = 8;
    localparam int          PROB_W = 4;
    localparam int          NSEG   = GENE_W / SEG_W;
    localparam logic [31:0] SEED0  = 32'h0000_0001;
    localparam logic [31:0] TAPS   = 32'h8020_0003;
    localparam logic [31:0] P0     = 32'hAAAA_AAAA;
    localparam logic [31:0] P1     = 32'h5555_5555;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, bias, seed_load, out_valid, out_ready;
    logic [GENE_W-1:0] parent_gene0, parent_gene1, child_gene;
    logic [1:0]        mode;
    logic [PROB_W-1:0] prob;
    logic [31:0]       seed;
    logic [NSEG-1:0]   sel_mask;

    always #5 clk = ~clk;

    crossover_engine #(.GENE_W(GENE_W), .SEG_W(SEG_W), .PROB_W(PROB_W), .LFSR_SEED(SEED0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .parent_gene0(parent_gene0), .parent_gene1(parent_gene1), .mode(mode),
        .prob(prob), .bias(bias), .seed_load(seed_load), .seed(seed),
        .out_valid(out_valid), .out_ready(out_ready), .child_gene(child_gene),
        .sel_mask(sel_mask)
    );

    typedef struct {
        logic [31:0] child;
        logic [3:0]  mask;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0, n_fail = 0, pops = 0;
    logic [31:0] m_lfsr = SEED0;
    logic        last_acc = 1'b0, prev_stall = 1'b0;
    logic [31:0] last_child, prev_child;
    logic [3:0]  last_mask, prev_mask;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : 32'h0);
    endfunction

    // Mask straight from the crossover rules, using division/modulo on the LFSR word.
    function automatic logic [3:0] ref_mask(input logic [31:0] r, input logic [1:0] m,
                                            input int p, input bit b);
        int c0, c1, lo, hi, ri;
        logic [3:0] mk;
        c0 = int'(r % NSEG);
        c1 = int'((r / NSEG) % NSEG);
        lo = (c0 < c1) ? c0 : c1;
        hi = (c0 < c1) ? c1 : c0;
        mk = '0;
        for (int i = 0; i < NSEG; i++) begin
            ri = int'((r >> (PROB_W * i)) % (1 << PROB_W));
            case (m)
                2'd1:    mk[i] = (ri < p) != b;
                2'd2:    mk[i] = (i >= c0);
                2'd3:    mk[i] = (i >= lo) && (i < hi);
                default: mk[i] = 1'b0;
            endcase
        end
        return mk;
    endfunction

    function automatic logic [31:0] ref_child(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] mk);
        logic [31:0] c;
        c = 32'h0;
        for (int i = 0; i < NSEG; i++)
            c = c | ((((mk[i] ? b : a) >> (SEG_W * i)) & 32'hFF) << (SEG_W * i));
        return c;
    endfunction

    // One clock: observe before the edge, update the model, then check the LFSR after it.
    task automatic tick();
        exp_t e;
        logic acc;
        @(negedge clk);
        chk("in_ready", in_ready, !rst && (!out_valid || out_ready));
        if (prev_stall && !rst) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_child", child_gene, prev_child);
            chk("hold_mask", sel_mask, prev_mask);
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_child = child_gene;
        prev_mask  = sel_mask;
        if (!rst && out_valid && out_ready) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("child", child_gene, e.child);
                chk("mask", sel_mask, e.mask);
                last_child = child_gene;
                last_mask  = sel_mask;
                pops++;
            end
        end
        acc = in_valid && in_ready;
        if (rst) begin
            exp_q.delete();
            m_lfsr = SEED0;
        end else begin
            if (acc) begin
                e.mask  = ref_mask(m_lfsr, mode, int'(prob), bias);
                e.child = ref_child(parent_gene0, parent_gene1, e.mask);
                exp_q.push_back(e);
            end
            if (seed_load)     m_lfsr = (seed == 32'h0) ? 32'h1 : seed;
            else if (acc)      m_lfsr = ref_step(m_lfsr);
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        chk("lfsr", dut.u_lfsr.lfsr_q, m_lfsr);
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_load = 1'b1;
        seed      = s;
        tick();
        seed_load = 1'b0;
    endtask

    // Single transaction into an idle pipeline, with latency measured in edges.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                           input logic [3:0] p, input logic bb);
        int lat, p0;
        p0 = pops;
        parent_gene0 = a; parent_gene1 = b; mode = m; prob = p; bias = bb;
        in_valid = 1'b1;
        tick();
        chk("accept", last_acc, 1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("latency", lat, 2);
        for (int k = 0; k < 10 && pops == p0; k++) tick();
        chk("output_arrived", pops - p0, 1);
    endtask

    logic [31:0] bp_a[4], bp_b[4], m0, exp4, s_col, old_l;
    logic [1:0]  bp_m[4];
    logic [3:0]  bp_p[4];
    int          sent, pb;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; seed_load = 1'b0; seed = '0;
        parent_gene0 = '0; parent_gene1 = '0; mode = 2'd0; prob = '0; bias = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_child", child_gene, 0);
        chk("rst_mask", sel_mask, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        run_one(P0, P1, 2'd0, 4'd0, 1'b0);
        chk("pass_child", last_child, 32'hAAAA_AAAA);
        chk("pass_mask", last_mask, 4'b0000);

        load_seed(32'h0000_3A71);
        run_one(P0, P1, 2'd1, 4'd4, 1'b0);
        chk("unif_mask", last_mask, 4'b1001);
        chk("unif_child", last_child, 32'h55AA_AA55);
        load_seed(32'h0000_3A71);
        run_one(P0, P1, 2'd1, 4'd0, 1'b1);
        chk("unif_bias_mask", last_mask, 4'b1111);
        chk("unif_bias_child", last_child, P1);

        load_seed(32'h0000_0002);
        run_one(P0, P1, 2'd2, 4'd0, 1'b0);
        chk("onept_mask", last_mask, 4'b1100);
        chk("onept_child", last_child, 32'h5555_AAAA);
        load_seed(32'h0000_0007);
        run_one(P0, P1, 2'd3, 4'd0, 1'b0);
        chk("twopt_mask", last_mask, 4'b0110);
        chk("twopt_child", last_child, 32'hAA55_55AA);
        load_seed(32'h0000_0005);
        run_one(P0, P1, 2'd3, 4'd0, 1'b0);
        chk("twopt_eq_mask", last_mask, 4'b0000);
        chk("twopt_eq_child", last_child, P0);

        // Backpressure: four queued transactions, downstream stalled for five cycles.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = $urandom; bp_b[i] = $urandom;
            bp_m[i] = 2'($urandom_range(3)); bp_p[i] = 4'($urandom_range(15));
        end
        m0 = m_lfsr; pb = pops; sent = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                parent_gene0 = bp_a[sent]; parent_gene1 = bp_b[sent];
                mode = bp_m[sent]; prob = bp_p[sent]; bias = sent[0];
            end
            if (c == 2) chk("bp_in_ready_low", in_ready, 0);
            tick();
            if (last_acc) sent++;
        end
        in_valid = 1'b0;
        chk("bp_sent", sent, 4);
        chk("bp_outputs", pops - pb, 4);
        chk("bp_queue_empty", exp_q.size(), 0);
        exp4 = m0;
        for (int i = 0; i < 4; i++) exp4 = ref_step(exp4);
        chk("bp_lfsr_adv4", dut.u_lfsr.lfsr_q, exp4);

        // Randomized stream with random stalls and occasional reseeds.
        for (int c = 0; c < 200; c++) begin
            in_valid     = 1'($urandom_range(1));
            out_ready    = ($urandom_range(3) != 0);
            parent_gene0 = $urandom; parent_gene1 = $urandom;
            mode = 2'($urandom_range(3)); prob = 4'($urandom_range(15)); bias = 1'($urandom_range(1));
            seed_load    = ($urandom_range(15) == 0);
            seed         = $urandom;
            tick();
        end
        in_valid = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("rand_drained", exp_q.size(), 0);

        // Seed load colliding with an accepted transaction.
        s_col = 32'h1234_5678;
        old_l = m_lfsr;
        parent_gene0 = P0; parent_gene1 = P1; mode = 2'd1; prob = 4'd8; bias = 1'b0;
        in_valid = 1'b1; seed_load = 1'b1; seed = s_col;
        tick();
        chk("col_accept", last_acc, 1);
        chk("col_lfsr_is_seed", dut.u_lfsr.lfsr_q, s_col);
        in_valid = 1'b0; seed_load = 1'b0;
        pb = pops;
        for (int k = 0; k < 10 && pops == pb; k++) tick();
        chk("col_old_mask", last_mask, ref_mask(old_l, 2'd1, 8, 1'b0));
        run_one(P0, P1, 2'd1, 4'd8, 1'b0);
        chk("col_new_mask", last_mask, ref_mask(s_col, 2'd1, 8, 1'b0));
        load_seed(32'h0);
        chk("seed_zero_lfsr", dut.u_lfsr.lfsr_q, 32'h1);

        // Reset with two transactions in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        parent_gene0 = $urandom; parent_gene1 = $urandom; mode = 2'd1;
        tick();
        chk("rst_mid_acc0", last_acc, 1);
        tick();
        chk("rst_mid_acc1", last_acc, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        pb = pops;
        tick();
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_lfsr", dut.u_lfsr.lfsr_q, SEED0);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_mid_in_ready", in_ready, 1);
        repeat (6) tick();
        chk("rst_mid_no_output", pops - pb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/crossover_engine.md
# crossover_engine

Parametrised, pipelined crossover unit for the GA datapath: takes two parent genes per transaction, builds a per-segment select mask from an internal LFSR according to a run-time crossover mode, and emits the child gene. It generalises the fixed 8-bit single-selector crossover to N segments of any width. It adds uniform, single-point and two-point modes, seedable randomness and valid/ready flow control. It sits between parent selection and the mutation stage.

## Interface
- GENE_W, 32, gene width in bits; must be a multiple of SEG_W.
- SEG_W, 8, segment granularity; NSEG = GENE_W/SEG_W, which must be a power of two, 2..16.
- PROB_W, 4, width of the probability/random compare; NSEG*PROB_W ≤ 32.
- LFSR_SEED, 32'h0000_0001, LFSR reset value; must be nonzero.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  parent pair and controls valid.
- in_ready  out  1  engine accepts this cycle.
- parent_gene0  in  GENE_W  parent A.
- parent_gene1  in  GENE_W  parent B.
- mode  in  2  00 pass (A), 01 uniform, 10 single-point, 11 two-point.
- prob  in  PROB_W  uniform-mode threshold.
- bias  in  1  uniform-mode select inversion.
- seed_load  in  1  load LFSR from seed.
- seed  in  32  LFSR seed value.
- out_valid  out  1  child valid.
- out_ready  in  1  downstream accepts.
- child_gene  out  GENE_W  child gene.
- sel_mask  out  NSEG  mask used; bit i=1 means segment i came from parent_gene1.

## Operation
- Segment i occupies bits [i*SEG_W +: SEG_W]. L = log2(NSEG). The 32-bit LFSR value current in the acceptance cycle drives the mask.
- mode 00: mask = 0.
- mode 01: r_i = lfsr[i*PROB_W +: PROB_W]; mask[i] = (r_i < prob) ^ bias. The compare is unsigned.
- mode 10: c = lfsr[L-1:0]; mask[i] = (i ≥ c). When c = 0, the child is a full copy of parent_gene1.
- mode 11: c0 = lfsr[L-1:0], c1 = lfsr[2L-1:L]; lo = min(c0,c1), hi = max(c0,c1); mask[i] = (lo ≤ i < hi). When c0 = c1, mask = 0.
- child segment i = mask[i] ? parent_gene1 seg i : parent_gene0 seg i.
- LFSR update: Galois right-shift, taps 32'h8020_0003: lfsr ← (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
- The LFSR advances once per accepted transaction (in_valid & in_ready).
- seed_load has priority over the advance in the same cycle. It loads seed, or 32'h1 if seed = 0.
- A transaction accepted in the same cycle as seed_load uses the pre-load LFSR value.

## Timing
- Two register stages:
  - S1 captures the parents and the computed mask.
  - S2 holds child_gene, sel_mask and out_valid.
- en = !out_valid | out_ready. Both stages advance only on en; bubbles propagate as invalid.
- in_ready = en & !rst.
- Latency is 2 cycles from the acceptance edge to out_valid, with out_ready held high. Throughput is 1 transaction per cycle.
- While out_valid & !out_ready:
  - child_gene and sel_mask hold stable.
  - No acceptance, loss or duplication occurs.
- Reset values: out_valid 0, child_gene 0, sel_mask 0, S1 valid 0, lfsr LFSR_SEED. in_ready reads 0 while rst is high and 1 in the first cycle after.
- Reset mid-stream discards all in-flight transactions. No output is produced for them.

## Structure
- Package crossover_pkg holds:
  - mode encodings (XO_PASS, XO_UNIFORM, XO_ONEPT, XO_TWOPT);
  - LFSR_TAPS = 32'h8020_0003;
  - the width-legality checks.
- Sub-module crossover_lfsr holds the 32-bit register, seed load and advance enable.
- Mask generation and the muxing stay in crossover_engine.

## Test plan
Default parameters throughout; p0 = 32'hAAAA_AAAA, p1 = 32'h5555_5555.
- Pass mode:
  - Stimulus: mode 00, out_ready = 1.
  - Required: child = 32'hAAAA_AAAA, sel_mask = 4'b0000, out_valid exactly 2 cycles after acceptance.
- Uniform mode, seeded:
  - Stimulus: seed_load with seed 32'h0000_3A71, then mode 01, prob = 4, bias = 0.
  - Required: mask 4'b1001, child 32'h55AA_AA55.
  - Same seed with prob = 0, bias = 1: mask 4'b1111, child = p1.
- Single-point and two-point modes:
  - Single-point: seed 32'h0000_0002, mode 10. Required: mask 4'b1100, child 32'h5555_AAAA.
  - Two-point: seed 32'h0000_0007 (c0 = 3, c1 = 1), mode 11. Required: mask 4'b0110, child 32'hAA55_55AA.
  - Two-point with seed 32'h0000_0005 (c0 = c1): mask 0.
- Backpressure:
  - Stimulus: stream of 4 transactions with out_ready low for 5 cycles.
  - Required:
    - in_ready drops once both stages are full;
    - outputs hold stable while stalled;
    - all 4 children arrive in order, none duplicated;
    - the LFSR advanced exactly 4 times.
- Seed and advance collision:
  - Stimulus: seed_load together with an accepted transaction.
  - Required: the transaction uses the old LFSR value; the LFSR then equals seed; the next transaction uses seed.
  - seed = 0 loads 32'h1.
- Reset mid-operation:
  - Stimulus: assert rst with 2 transactions in flight.
  - Required: out_valid = 0 next cycle, both transactions are never output, lfsr = LFSR_SEED, in_ready = 1 after rst is released.
